// File: rtl/ks_sum_pkg.sv
// ks_sum_pkg: shared width, result struct and occupancy state for the Kogge-Stone adder back end
package ks_sum_pkg;
   localparam int KS_W = 8;
   typedef struct packed {
      logic [KS_W-1:0] sum;
      logic            cout;
      logic            ovf;
   } ks_res_t;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/ks_sum_if.sv
// ks_sum_if: operand/result handshake bundle between the last prefix stage, ks_sum and its consumer
interface ks_sum_if #(parameter int W = 8, parameter int CNT_W = 16);
   logic             i_valid;
   logic             o_ready;
   logic             i_c0;
   logic [W-1:0]     i_gk;
   logic [W-1:0]     i_p_save;
   logic             o_valid;
   logic             i_ready;
   logic [W-1:0]     o_sum;
   logic             o_cout;
   logic             o_ovf;
   logic [CNT_W-1:0] o_count;
   modport slave (input i_valid, i_c0, i_gk, i_p_save, i_ready,
                  output o_ready, o_valid, o_sum, o_cout, o_ovf, o_count);
   modport master (output i_valid, i_c0, i_gk, i_p_save, i_ready,
                   input o_ready, o_valid, o_sum, o_cout, o_ovf, o_count);
endinterface

// File: rtl/ks_sum_calc.sv
// ks_sum_calc: forms sum, carry-out and signed overflow from prefix carries and saved propagates
module ks_sum_calc #(parameter int W = 8) (
   input  logic         c0,
   input  logic [W-1:0] gk,
   input  logic [W-1:0] p_save,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   always_comb begin
      sum  = p_save ^ {gk[W-2:0], c0};
      cout = gk[W-1];
      ovf  = gk[W-1] ^ gk[W-2];
   end
endmodule

// File: rtl/ks_sum.sv
// ks_sum: adder post-processing with a 2-entry skid buffer and delivered-result counter
module ks_sum
   import ks_sum_pkg::*;
#(
   parameter int W     = KS_W,
   parameter int CNT_W = 16
) (
   input logic     i_clk,
   input logic     i_rst,
   ks_sum_if.slave bus
);
   logic [W-1:0]     sum;
   logic             cout;
   logic             ovf;
   logic [W+1:0]     entry;
   logic [W+1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   occ_t             state_q, state_d;
   logic             push, pop;
   ks_sum_calc #(.W(W)) u_calc (
      .c0    (bus.i_c0),
      .gk    (bus.i_gk),
      .p_save(bus.i_p_save),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );
   always_comb begin
      entry   = {sum, cout, ovf};
      push    = bus.i_valid && state_q != TWO;
      pop     = state_q != EMPTY && bus.i_ready;
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(pop);
      case (state_q)
         EMPTY: if (push) begin
            state_d = ONE;
            head_d  = entry;
         end
         ONE: begin
            if (push && pop) head_d = entry;
            else if (push) begin
               state_d = TWO;
               tail_d  = entry;
            end else if (pop) state_d = EMPTY;
         end
         TWO: if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   always_comb begin
      bus.o_valid                         = state_q != EMPTY;
      bus.o_ready                         = state_q != TWO;
      {bus.o_sum, bus.o_cout, bus.o_ovf}  = head_q;
      bus.o_count                         = count_q;
   end
endmodule

// File: tb/tb_ks_sum.sv
// tb_ks_sum: directed checks of ks_sum arithmetic, skid buffering, counter and reset
module tb_ks_sum;
   import ks_sum_pkg::*;
   logic clk, rst;
   int   total, bad, cnt_e;
   ks_sum_if #(.W(8), .CNT_W(16)) bus ();
   ks_sum #(.W(8), .CNT_W(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   function automatic ks_res_t model(input logic [7:0] a, b, input logic c0);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + {8'd0, c0};
      model.sum  = s[7:0];
      model.cout = s[8];
      model.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
   endfunction
   task automatic drive(input logic [7:0] a, b, input logic c0, input logic v);
      logic c;
      c = c0;
      for (int i = 0; i < 8; i++) begin
         c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
         bus.i_gk[i] = c;
      end
      bus.i_p_save = a ^ b;
      bus.i_c0     = c0;
      bus.i_valid  = v;
   endtask
   task automatic chk_head(input string tag, input ks_res_t e);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      chk({tag, "_sum"}, 32'(bus.o_sum), 32'(e.sum));
      chk({tag, "_cout"}, 32'(bus.o_cout), 32'(e.cout));
      chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(e.ovf));
   endtask
   task automatic add_one(input string tag, input logic [7:0] a, b, input logic c0);
      bus.i_ready = 1;
      drive(a, b, c0, 1);
      cyc();
      drive(8'h00, 8'h00, 0, 0);
      chk_head(tag, model(a, b, c0));
      cyc();
      cnt_e++;
      chk({tag, "_drain"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.o_count), 32'(cnt_e));
   endtask
   logic [7:0] sa [256];
   logic [7:0] sb [256];
   logic       sc [256];
   initial begin
      total = 0;
      bad   = 0;
      cnt_e = 0;
      rst   = 1;
      bus.i_ready = 0;
      drive(8'h00, 8'h00, 0, 0);
      cyc();
      cyc();
      rst = 0;
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_sum", 32'(bus.o_sum), 32'd0);
      chk("rst_cnt", 32'(bus.o_count), 32'd0);
      bus.i_ready = 1;
      drive(8'hA5, 8'h11, 1, 0);
      repeat (3) cyc();
      chk("idle_valid", 32'(bus.o_valid), 32'd0);
      chk("idle_sum", 32'(bus.o_sum), 32'd0);
      chk("idle_cnt", 32'(bus.o_count), 32'd0);
      add_one("add5a3c", 8'h5A, 8'h3C, 0);
      chk("add5a3c_abs", 32'(cnt_e), 32'(bus.o_count));
      add_one("addff01", 8'hFF, 8'h01, 0);
      add_one("addc0", 8'h00, 8'h00, 1);
      add_one("addneg", 8'h80, 8'h80, 0);
      // backpressure: A and B absorbed, C held off until the buffer drains
      bus.i_ready = 0;
      drive(8'h12, 8'h34, 0, 1);
      cyc();
      chk_head("bpA", model(8'h12, 8'h34, 0));
      chk("bpA_ready", 32'(bus.o_ready), 32'd1);
      drive(8'h7F, 8'h01, 0, 1);
      cyc();
      chk("bpB_ready", 32'(bus.o_ready), 32'd0);
      chk_head("bpB_hold", model(8'h12, 8'h34, 0));
      drive(8'hC0, 8'hC0, 1, 1);
      cyc();
      chk("bpC_ready", 32'(bus.o_ready), 32'd0);
      chk_head("bpC_hold", model(8'h12, 8'h34, 0));
      bus.i_ready = 1;
      cyc();
      cnt_e++;
      chk_head("bp_outB", model(8'h7F, 8'h01, 0));
      chk("bp_ready_up", 32'(bus.o_ready), 32'd1);
      chk("bp_cnt1", 32'(bus.o_count), 32'(cnt_e));
      cyc();
      cnt_e++;
      drive(8'h00, 8'h00, 0, 0);
      chk_head("bp_outC", model(8'hC0, 8'hC0, 1));
      cyc();
      cnt_e++;
      chk("bp_empty", 32'(bus.o_valid), 32'd0);
      chk("bp_cnt", 32'(bus.o_count), 32'(cnt_e));
      for (int k = 0; k < 256; k++) begin
         sa[k] = 8'($urandom);
         sb[k] = 8'($urandom);
         sc[k] = 1'($urandom);
      end
      for (int k = 0; k < 256; k++) begin
         drive(sa[k], sb[k], sc[k], 1);
         chk("str_ready_in", 32'(bus.o_ready), 32'd1);
         cyc();
         chk_head("str", model(sa[k], sb[k], sc[k]));
      end
      drive(8'h00, 8'h00, 0, 0);
      cyc();
      cnt_e += 256;
      chk("str_empty", 32'(bus.o_valid), 32'd0);
      chk("str_cnt", 32'(bus.o_count), 32'(cnt_e));
      bus.i_ready = 0;
      drive(8'h01, 8'h02, 0, 1);
      cyc();
      drive(8'h03, 8'h04, 0, 1);
      cyc();
      chk("mid_two", 32'(bus.o_ready), 32'd0);
      bus.i_ready = 1;
      rst = 1;
      cyc();
      rst = 0;
      cnt_e = 0;
      drive(8'h00, 8'h00, 0, 0);
      chk("mid_valid", 32'(bus.o_valid), 32'd0);
      chk("mid_ready", 32'(bus.o_ready), 32'd1);
      chk("mid_sum", 32'(bus.o_sum), 32'd0);
      chk("mid_cnt", 32'(bus.o_count), 32'd0);
      add_one("post_rst", 8'h9C, 8'h2B, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ks_sum.md
# ks_sum

Final post-processing stage of the 8-bit Kogge-Stone adder pipeline, directly downstream of the last prefix stage (the span-4 combine). Consumes the carry-in, the group-generate vector and the saved propagate vector that stage emits, forms the sum, carry-out and signed overflow, and registers them into a 2-entry skid buffer with valid/ready handshaking on both sides. It also keeps a wrapping count of results delivered downstream.

## Interface
- W, default 8: adder width; must be ≥ 2.
- CNT_W, default 16: width of the delivered-result counter.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  upstream has a valid operand set this cycle.
- o_ready  output  1  block can accept an operand set this cycle.
- i_c0  input  1  adder carry-in, passed through by the prefix stages.
- i_gk  input  W  group generate; i_gk[i] = carry out of bit i, including i_c0.
- i_p_save  input  W  per-bit propagate (a ^ b), saved from the pre-processing stage.
- o_valid  output  1  head result valid.
- i_ready  input  1  downstream accepts the head result this cycle.
- o_sum  output  W  sum of the head result.
- o_cout  output  1  unsigned carry-out of the head result.
- o_ovf  output  1  two's-complement overflow of the head result.
- o_count  output  CNT_W  number of results delivered downstream, mod 2^CNT_W.

## Operation
- Arithmetic, combinational on inputs before buffering:
  - sum[0] = i_p_save[0] ^ i_c0.
  - sum[i] = i_p_save[i] ^ i_gk[i-1] for 1 ≤ i < W.
  - cout = i_gk[W-1].
  - ovf = i_gk[W-1] ^ i_gk[W-2].
- Entry = {sum, cout, ovf}. There is a head register, a tail register and an occupancy state.
- Push when i_valid && o_ready. Pop when o_valid && i_ready.
- States:
  - EMPTY:
    - push → ONE (head ← entry).
    - No push → stay in EMPTY.
  - ONE:
    - push && pop → ONE (head ← entry).
    - push only → TWO (tail ← entry).
    - pop only → EMPTY.
    - Neither → hold.
  - TWO:
    - pop → ONE (head ← tail).
    - No pop → hold. No push is possible in TWO.
- o_valid = (state != EMPTY). Outputs always show the head register.
- o_ready = (state != TWO). Driven from the state register, not from i_ready, so there is no combinational ready path.
- Inputs are ignored and not sampled when no push occurs. Buffer contents never change except by push or pop.
- o_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Reset:
  - State EMPTY; o_valid 0; o_ready 1.
  - o_sum, o_cout, o_ovf = 0; tail = 0; o_count = 0.
  - Reset mid-operation discards buffered entries. A push or pop in the reset cycle has no effect.

## Timing
- Latency: an operand set pushed in cycle N is presented with o_valid=1 in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 result per cycle while i_ready is held high.
- Backpressure: with i_ready low, two pushes are absorbed and o_ready falls the cycle after the second push. o_ready rises the cycle after the first subsequent pop.
- Order: strictly FIFO; no entry is dropped or duplicated.
- o_valid/o_sum are stable while o_valid && !i_ready.
- o_count updates the cycle after the pop.

## Structure
- Shared adder package holds:
  - the W default constant;
  - a packed result struct {sum, cout, ovf};
  - the occupancy state enum {EMPTY, ONE, TWO}.
- One natural sub-module, ks_sum_calc: the combinational sum/cout/ovf formation, parameterised by W, instantiated once ahead of the buffer.
- Buffer, state machine and counter live in ks_sum itself.

## Test plan
- Reset and idle:
  - Hold i_rst 2 cycles → o_valid=0, o_ready=1, o_sum=0, o_count=0.
  - i_valid=0 thereafter → nothing changes.
- Single add, a=0x5A, b=0x3C, c0=0 (p_save=0x66, gk per prefix of G=0x18) → next cycle o_sum=0x96, o_cout=0, o_ovf=1; o_count=1 after the pop.
- Carry-out case, a=0xFF, b=0x01, c0=0 → o_sum=0x00, o_cout=1, o_ovf=0. With c0=1 and a=b=0x00 → o_sum=0x01, o_cout=0, o_ovf=0.
- Backpressure:
  - i_ready=0 with pushes of A, B, C offered → A and B accepted, o_ready=0 from the cycle after B, C held off.
  - Then i_ready=1 → A, B, C delivered in order; o_count=3.
- Streaming: 256 back-to-back random pushes with i_ready=1 → one result per cycle, each matching (a+b+c0) mod 256 with correct cout/ovf, o_ready never low.
- Reset mid-operation: buffer in TWO, assert i_rst for 1 cycle → o_valid=0, o_ready=1, o_count=0; next push is delivered normally.
